pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the five-stage integer core. It merges stall requests from IF, ID, EX and MEM into one per-stage stall vector that drives the pc_reg and pipeline registers. It sequences multi-cycle flushes with a redirect PC and watches for stuck stalls. It also keeps saturating stall and flush performance counters.

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Stall/flush bus between the integer core pipeline and pipe_ctrl.
// master = pipeline side (raises requests), slave = controller.
interface pipe_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output flush_req_i, flush_pc_i,
    input  stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  flush_req_i, flush_pc_i,
    output stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority stall merge, multi-cycle flush
// sequencing with redirect PC, stuck-stall watchdog and saturating perf counters.
module pipe_ctrl #(
  parameter int MAX_STALL    = 1024,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [15:0] MAX_STALL_W = 16'(MAX_STALL);
  localparam logic [3:0]  FLUSH_LEN   = 4'(FLUSH_CYCLES);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state;
  logic [3:0]  flush_left;
  logic [15:0] wd_cnt;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic        timeout_q;
  logic [5:0]  stall_vec;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Deeper stages freeze everything upstream of them; IF and ID share a mask.
  always_comb begin
    stall_vec = 6'b000000;
    if (!rst && state == RUN) begin
      if (bus.stallreq_mem_i)
        stall_vec = 6'b011111;
      else if (bus.stallreq_ex_i)
        stall_vec = 6'b001111;
      else if (bus.stallreq_id_i || bus.stallreq_if_i)
        stall_vec = 6'b000111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_left <= 4'd0;
      wd_cnt     <= 16'd0;
      stall_cnt  <= 32'd0;
      flush_cnt  <= 16'd0;
      flush_q    <= 1'b0;
      new_pc_q   <= 32'd0;
      timeout_q  <= 1'b0;
    end else begin
      if (stall_vec != 6'b000000)
        stall_cnt <= sat_inc32(stall_cnt);

      // Watchdog only tracks pc stalls; saturates so the flag can never re-arm.
      if (stall_vec[0]) begin
        if (wd_cnt != MAX_STALL_W)
          wd_cnt <= wd_cnt + 16'd1;
        if (wd_cnt == MAX_STALL_W - 16'd1)
          timeout_q <= 1'b1;
      end else begin
        wd_cnt <= 16'd0;
      end

      case (state)
        RUN: begin
          if (bus.flush_req_i) begin
            state      <= FLUSH;
            flush_q    <= 1'b1;
            new_pc_q   <= bus.flush_pc_i;
            flush_left <= FLUSH_LEN;
            flush_cnt  <= sat_inc16(flush_cnt);
          end
        end
        FLUSH: begin
          // A newer redirect restarts the whole flush window.
          if (bus.flush_req_i) begin
            new_pc_q   <= bus.flush_pc_i;
            flush_left <= FLUSH_LEN;
            flush_cnt  <= sat_inc16(flush_cnt);
          end else if (flush_left == 4'd1) begin
            state   <= RUN;
            flush_q <= 1'b0;
          end else begin
            flush_left <= flush_left - 4'd1;
          end
        end
        default: begin
          state   <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall_o         = stall_vec;
  assign bus.flush_o         = flush_q;
  assign bus.new_pc_o        = new_pc_q;
  assign bus.stall_timeout_o = timeout_q;
  assign bus.stall_cnt_o     = stall_cnt;
  assign bus.flush_cnt_o     = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with FLUSH_CYCLES = 3 and MAX_STALL = 8.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pipe_ctrl_if pif();

  pipe_ctrl #(.MAX_STALL(8), .FLUSH_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pif.stallreq_if_i  = 1'b0;
    pif.stallreq_id_i  = 1'b0;
    pif.stallreq_ex_i  = 1'b0;
    pif.stallreq_mem_i = 1'b0;
    pif.flush_req_i    = 1'b0;
    pif.flush_pc_i     = 32'd0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    pif.stallreq_mem_i = 1'b1;
    tick();
    tests++;
    if (pif.stall_o !== 6'b000000) begin
      fails++; $display("FAIL reset_stall: got %b expected 000000", pif.stall_o);
    end
    tests++;
    if (pif.flush_o !== 1'b0 || pif.new_pc_o !== 32'd0 || pif.stall_timeout_o !== 1'b0) begin
      fails++; $display("FAIL reset_regs: flush=%b pc=%h to=%b expected 0/0/0",
                        pif.flush_o, pif.new_pc_o, pif.stall_timeout_o);
    end
    tests++;
    if (pif.stall_cnt_o !== 32'd0 || pif.flush_cnt_o !== 16'd0) begin
      fails++; $display("FAIL reset_cnts: stall_cnt=%0d flush_cnt=%0d expected 0/0",
                        pif.stall_cnt_o, pif.flush_cnt_o);
    end
    pif.stallreq_mem_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_priority();
    logic [3:0] reqs [6];   // {mem, ex, id, if}
    logic [5:0] exp  [6];
    reqs[0] = 4'b1000; exp[0] = 6'b011111;
    reqs[1] = 4'b0100; exp[1] = 6'b001111;
    reqs[2] = 4'b0010; exp[2] = 6'b000111;
    reqs[3] = 4'b0001; exp[3] = 6'b000111;
    reqs[4] = 4'b1010; exp[4] = 6'b011111;
    reqs[5] = 4'b0000; exp[5] = 6'b000000;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      {pif.stallreq_mem_i, pif.stallreq_ex_i, pif.stallreq_id_i, pif.stallreq_if_i} = reqs[i];
      #1;
      tests++;
      if (pif.stall_o !== exp[i]) begin
        fails++; $display("FAIL prio_run[%0d]: got %b expected %b", i, pif.stall_o, exp[i]);
      end
    end
    clear_inputs();
    pif.flush_req_i = 1'b1;
    tick();
    pif.flush_req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {pif.stallreq_mem_i, pif.stallreq_ex_i, pif.stallreq_id_i, pif.stallreq_if_i} = reqs[i];
      #1;
      tests++;
      if (pif.stall_o !== 6'b000000) begin
        fails++; $display("FAIL prio_flush[%0d]: got %b expected 000000", i, pif.stall_o);
      end
    end
    clear_inputs();
  endtask

  task automatic test_single_flush();
    int n = 0;
    apply_reset();
    pif.flush_req_i   = 1'b1;
    pif.flush_pc_i    = 32'h0000_0020;
    pif.stallreq_ex_i = 1'b1;
    #1;
    tests++;
    if (pif.stall_o !== 6'b001111) begin
      fails++; $display("FAIL flush_same_cycle_stall: got %b expected 001111", pif.stall_o);
    end
    tick();
    clear_inputs();
    tests++;
    if (pif.new_pc_o !== 32'h20 || pif.flush_cnt_o !== 16'd1) begin
      fails++; $display("FAIL single_pc_cnt: pc=%h cnt=%0d expected 20/1", pif.new_pc_o, pif.flush_cnt_o);
    end
    for (int i = 0; i < 10; i++) begin
      if (pif.flush_o === 1'b1) n++;
      tick();
    end
    tests++;
    if (n != 3) begin
      fails++; $display("FAIL single_len: flush_o high %0d cycles expected 3", n);
    end
    pif.stallreq_if_i = 1'b1;
    #1;
    tests++;
    if (pif.stall_o !== 6'b000111) begin
      fails++; $display("FAIL single_back_to_run: stall got %b expected 000111", pif.stall_o);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    apply_reset();
    pif.flush_req_i = 1'b1;
    pif.flush_pc_i  = 32'h0000_0020;
    tick();
    pif.flush_pc_i  = 32'h0000_0040;
    n++;
    tick();
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      if (pif.flush_o === 1'b1) n++;
      tick();
    end
    tests++;
    if (n != 4) begin
      fails++; $display("FAIL b2b_len: flush_o high %0d cycles expected 4", n);
    end
    tests++;
    if (pif.new_pc_o !== 32'h40 || pif.flush_cnt_o !== 16'd2) begin
      fails++; $display("FAIL b2b_pc_cnt: pc=%h cnt=%0d expected 40/2", pif.new_pc_o, pif.flush_cnt_o);
    end
  endtask

  task automatic test_watchdog();
    apply_reset();
    pif.stallreq_ex_i = 1'b1;
    repeat (7) tick();
    tests++;
    if (pif.stall_timeout_o !== 1'b0) begin
      fails++; $display("FAIL wd_after7: got %b expected 0", pif.stall_timeout_o);
    end
    pif.stallreq_ex_i = 1'b0;
    tick();
    pif.stallreq_ex_i = 1'b1;
    repeat (7) tick();
    tests++;
    if (pif.stall_timeout_o !== 1'b0) begin
      fails++; $display("FAIL wd_second7: got %b expected 0", pif.stall_timeout_o);
    end
    tick();
    tests++;
    if (pif.stall_timeout_o !== 1'b1) begin
      fails++; $display("FAIL wd_fire: got %b expected 1", pif.stall_timeout_o);
    end
    pif.stallreq_ex_i = 1'b0;
    repeat (2) tick();
    tests++;
    if (pif.stall_timeout_o !== 1'b1 || pif.stall_cnt_o !== 32'd15) begin
      fails++; $display("FAIL wd_sticky: to=%b stall_cnt=%0d expected 1/15",
                        pif.stall_timeout_o, pif.stall_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    pif.stallreq_mem_i = 1'b1;
    repeat (2) tick();
    pif.flush_req_i = 1'b1;
    pif.flush_pc_i  = 32'h0000_0080;
    tick();
    pif.flush_req_i = 1'b0;
    tests++;
    if (pif.flush_o !== 1'b1 || pif.stall_cnt_o !== 32'd3) begin
      fails++; $display("FAIL mid_setup: flush=%b stall_cnt=%0d expected 1/3", pif.flush_o, pif.stall_cnt_o);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (pif.stall_o !== 6'b000000) begin
      fails++; $display("FAIL mid_stall: got %b expected 000000", pif.stall_o);
    end
    tick();
    tests++;
    if (pif.flush_o !== 1'b0 || pif.stall_cnt_o !== 32'd0 || pif.flush_cnt_o !== 16'd0) begin
      fails++; $display("FAIL mid_regs: flush=%b stall_cnt=%0d flush_cnt=%0d expected 0/0/0",
                        pif.flush_o, pif.stall_cnt_o, pif.flush_cnt_o);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (pif.stall_o !== 6'b011111) begin
      fails++; $display("FAIL mid_run: stall got %b expected 011111", pif.stall_o);
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    apply_reset();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    pif.stallreq_if_i = 1'b1;
    tick();
    tests++;
    if (pif.stall_cnt_o !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL sat_reach: got %h expected ffffffff", pif.stall_cnt_o);
    end
    repeat (2) tick();
    tests++;
    if (pif.stall_cnt_o !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL sat_hold: got %h expected ffffffff", pif.stall_cnt_o);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_priority();
    test_single_flush();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
